// File: rtl/delay_pkg.sv
// rtl/delay_pkg.sv - shared types and helpers for the multi-lane delay line
//
// Contents:
//   state_t     : FILL/RUN state encoding
//   clamp_delay : maps a raw delay setting onto the legal range 1..max_delay
//   ptr_sub     : (wr - d) modulo depth, valid for any depth (not only 2^n)
package delay_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // A delay of 0 cannot be built from a registered output, so it becomes 1.
  function automatic int clamp_delay(input int cfg, input int max_delay);
    if (cfg < 1) return 1;
    if (cfg > max_delay) return max_delay;
    return cfg;
  endfunction

  // Caller guarantees 0 <= wr < depth and 1 <= d <= depth, so a single
  // conditional add of depth is enough to bring the result back in range.
  function automatic int ptr_sub(input int wr, input int d, input int depth);
    if (wr >= d) return wr - d;
    return wr + depth - d;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// rtl/delay_ram.sv - simple dual-port RAM, synchronous write, asynchronous read
//
// Ports:
//   clk_i   : write clock, rising edge
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (combinational read)
//   rdata_o : read data; shows the old contents when raddr_i == waddr_i
module delay_ram #(
  parameter  int DEPTH = 16,
  parameter  int DW    = 17,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/multi_delay_line.sv
// rtl/multi_delay_line.sv - programmable multi-lane delay line with priming status
//
// Ports:
//   CLK          : single clock, rising edge
//   RESET        : asynchronous active-high reset
//   DIN          : CHANNELS lanes of WIDTH bits, lane 0 in the LSBs
//   DIN_VALID    : qualifier travelling alongside DIN
//   DELAY_CFG    : new delay setting, taken when CFG_LOAD is high
//   CFG_LOAD     : one-cycle load strobe, restarts the fill
//   DOUT         : delayed samples (registered, zero while filling)
//   DOUT_VALID   : delayed DIN_VALID, low while filling
//   DELAY_READY  : buffer primed at the active delay
//   DELAY_ACTIVE : clamped delay currently in force
module multi_delay_line
  import delay_pkg::*;
#(
  parameter  int WIDTH         = 8,
  parameter  int CHANNELS      = 2,
  parameter  int MAX_DELAY     = 16,
  parameter  int DEFAULT_DELAY = 10,
  localparam int CFG_W         = $clog2(MAX_DELAY + 1)
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [CHANNELS*WIDTH-1:0] DIN,
  input  logic                      DIN_VALID,
  input  logic [CFG_W-1:0]          DELAY_CFG,
  input  logic                      CFG_LOAD,
  output logic [CHANNELS*WIDTH-1:0] DOUT,
  output logic                      DOUT_VALID,
  output logic                      DELAY_READY,
  output logic [CFG_W-1:0]          DELAY_ACTIVE
);

  localparam int DW    = CHANNELS * WIDTH;
  localparam int EW    = DW + 1;
  localparam int PTR_W = $clog2(MAX_DELAY);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_idx;
  logic [CFG_W-1:0] delay_q, delay_d;
  logic [CFG_W-1:0] fill_q, fill_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic             valid_q, valid_d;
  logic [EW-1:0]    rd_entry;

  // The entry written D edges ago sits D slots behind the write pointer.
  // When D == MAX_DELAY this is the slot being overwritten this edge; the
  // asynchronous read still returns its old contents, which is the wanted one.
  assign rd_idx = PTR_W'(ptr_sub(int'(wr_q), int'(delay_q), MAX_DELAY));

  delay_ram #(
    .DEPTH (MAX_DELAY),
    .DW    (EW)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (1'b1),
    .waddr_i (wr_q),
    .wdata_i ({DIN_VALID, DIN}),
    .raddr_i (rd_idx),
    .rdata_o (rd_entry)
  );

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    fill_d  = fill_q;
    dout_d  = '0;
    valid_d = 1'b0;
    wr_d    = (wr_q == PTR_W'(MAX_DELAY - 1)) ? '0 : wr_q + 1'b1;

    if (CFG_LOAD) begin
      state_d = ST_FILL;
      delay_d = CFG_W'(clamp_delay(int'(DELAY_CFG), MAX_DELAY));
      // The load edge itself stores the first sample of the new regime, so
      // it already counts as one filled edge.
      fill_d  = CFG_W'(1);
    end else if (state_q == ST_FILL) begin
      if (fill_q == delay_q) begin
        state_d = ST_RUN;
      end else begin
        fill_d = fill_q + 1'b1;
      end
    end

    // Output register follows the next state so that the edge entering RUN
    // already presents the oldest sample of the regime.
    if (state_d == ST_RUN) begin
      dout_d  = rd_entry[DW-1:0];
      valid_d = rd_entry[DW];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_FILL;
      wr_q    <= '0;
      delay_q <= CFG_W'(DEFAULT_DELAY);
      fill_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      delay_q <= delay_d;
      fill_q  <= fill_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign DOUT         = dout_q;
  assign DOUT_VALID   = valid_q;
  assign DELAY_READY  = (state_q == ST_RUN);
  assign DELAY_ACTIVE = delay_q;

endmodule
